// File: rtl/shift_seq_pkg.sv
// shift_pkg: shared definitions for the shift_seq multi-cycle shift/rotate unit.
//   - MODE_DIR / MODE_ROT / MODE_CSEL : bit positions inside the 3-bit mode field
//   - state_t                         : sequencer states ST_IDLE, ST_SHIFT, ST_DONE
//   - mode_t and SH_*                 : named operation codes
package shift_pkg;

    localparam int MODE_DIR  = 2;   // 0 = left, 1 = right
    localparam int MODE_ROT  = 1;   // 0 = fill, 1 = rotate
    localparam int MODE_CSEL = 0;   // fill: 1 = carry fill; rotate: 1 = through carry

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [2:0] mode_t;

    localparam mode_t SH_LZ  = 3'b000;  // left, zero fill
    localparam mode_t SH_LC  = 3'b001;  // left, fill with captured carry
    localparam mode_t SH_ROL = 3'b010;  // rotate left
    localparam mode_t SH_RCL = 3'b011;  // rotate left through carry
    localparam mode_t SH_RZ  = 3'b100;  // right, zero fill (arithmetic with SHIFT_ARITH_EN)
    localparam mode_t SH_RC  = 3'b101;  // right, fill with captured carry
    localparam mode_t SH_ROR = 3'b110;  // rotate right
    localparam mode_t SH_RCR = 3'b111;  // rotate right through carry

endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: start/ready/done handshake and data bus of the shift_seq unit.
//   master : sequencer side (drives start, in_data, cin, mode, amount)
//   slave  : shift unit side (drives ready, busy, done, out, cout)
interface shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             cin;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;

    modport master (
        output start, in_data, cin, mode, amount,
        input  ready, busy, done, out, cout
    );

    modport slave (
        input  start, in_data, cin, mode, amount,
        output ready, busy, done, out, cout
    );
endinterface

// File: rtl/shift_seq_step.sv
// shift_step: one combinational single-bit shift/rotate step.
//   d, c     : current working value and carry
//   cin_l    : carry captured when the operation was accepted
//   mode     : operation code (see shift_pkg)
//   d_next   : value after one step
//   c_next   : carry after one step (always the bit shifted out)
// Build option SHIFT_ARITH_EN: mode SH_RZ replicates the sign bit instead of
// filling with zero.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    input  logic             cin_l,
    input  mode_t            mode,
    output logic [WIDTH-1:0] d_next,
    output logic             c_next
);

    logic ob;
    logic nb;

    // ob is the bit leaving the word; nb is the bit entering from the other end.
    // Rotate-through-carry feeds the old carry in, giving a WIDTH+1 period.
    always_comb begin
        ob = mode[MODE_DIR] ? d[0] : d[WIDTH-1];
        nb = 1'b0;
        case ({mode[MODE_ROT], mode[MODE_CSEL]})
            2'b00: begin
`ifdef SHIFT_ARITH_EN
                nb = mode[MODE_DIR] ? d[WIDTH-1] : 1'b0;
`else
                nb = 1'b0;
`endif
            end
            2'b01:   nb = cin_l;
            2'b10:   nb = ob;
            2'b11:   nb = c;
            default: nb = 1'b0;
        endcase
        if (mode[MODE_DIR]) begin
            d_next = {nb, d[WIDTH-1:1]};
        end else begin
            d_next = {d[WIDTH-2:0], nb};
        end
        c_next = ob;
    end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate unit, one bit position per clock.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (aborts any operation, no done pulse)
//   bus : shift_seq_if.slave
//         start/in_data/cin/mode/amount are captured when start && ready
//         ready = idle, busy = shifting, done = one-cycle completion pulse
//         out/cout hold the last result until the next completion
// Build option SHIFT_ARITH_EN: see shift_step (arithmetic right shift on SH_RZ).
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_seq_if.slave  bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] d;
    logic             c;
    logic             cin_l;
    mode_t            mode_q;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] d_step;
    logic             c_step;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic             done_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d      (d),
        .c      (c),
        .cin_l  (cin_l),
        .mode   (mode_q),
        .d_next (d_step),
        .c_next (c_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero count skips SHIFT entirely; otherwise the step taken while
    // cnt==1 is the last one.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == ST_IDLE);
        bus.busy  = (state == ST_SHIFT);
        bus.done  = done_q;
        bus.out   = out_q;
        bus.cout  = cout_q;
    end

    // Datapath. done is registered on leaving DONE so it lines up with the
    // newly written out/cout, landing amount+1 cycles after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            d      <= '0;
            c      <= 1'b0;
            cin_l  <= 1'b0;
            mode_q <= SH_LZ;
            cnt    <= '0;
            out_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        d      <= bus.in_data;
                        c      <= bus.cin;
                        cin_l  <= bus.cin;
                        mode_q <= bus.mode;
                        cnt    <= bus.amount;
                    end
                end
                ST_SHIFT: begin
                    d   <= d_step;
                    c   <= c_step;
                    cnt <= cnt - AMT_W'(1);
                end
                ST_DONE: begin
                    out_q  <= d;
                    cout_q <= c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed self-checking bench for shift_seq (WIDTH=8, AMT_W=4).
// Honours SHIFT_ARITH_EN for the SH_RZ expectation.
module tb_shift_seq;
    import shift_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    shift_seq_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shift_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done. lat counts edges from
    // the accepting edge to the one after which done is seen.
    task automatic applyStimulus(input logic [7:0] d, input logic c, input mode_t m,
                                 input logic [3:0] a, output int lat,
                                 output logic saw_busy, output logic out_moved);
        logic [7:0] prev_out;
        @(negedge clk);
        bus.in_data = d;
        bus.cin     = c;
        bus.mode    = m;
        bus.amount  = a;
        bus.start   = 1'b1;
        prev_out    = bus.out;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.in_data = ~d;
        bus.cin     = ~c;
        bus.mode    = ~m;
        bus.amount  = ~a;
        lat       = 0;
        saw_busy  = 1'b0;
        out_moved = 1'b0;
        while (!bus.done && lat < 40) begin
            saw_busy  = saw_busy | bus.busy;
            out_moved = out_moved | (bus.out !== prev_out);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int         lat;
        int         dones;
        logic       sb;
        logic       om;
        logic [7:0] exp_rz;

        checks = 0;
        passes = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.in_data = '0;
        bus.cin     = 1'b0;
        bus.mode    = SH_LZ;
        bus.amount  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out",   32'(bus.out),   32'h00);
        checkOutput("reset_cout",  32'(bus.cout),  32'h0);
        checkOutput("reset_ready", 32'(bus.ready), 32'h1);
        checkOutput("reset_busy",  32'(bus.busy),  32'h0);
        checkOutput("reset_done",  32'(bus.done),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'hA5, 1'b1, SH_LC, 4'd3, lat, sb, om);
        checkOutput("lc_lat",    32'(lat),      32'd4);
        checkOutput("lc_out",    32'(bus.out),  32'h2F);
        checkOutput("lc_cout",   32'(bus.cout), 32'h1);
        checkOutput("lc_busy",   32'(sb),       32'h1);
        checkOutput("lc_stable", 32'(om),       32'h0);
        @(posedge clk);
        #1;
        checkOutput("lc_done_width", 32'(bus.done), 32'h0);
        checkOutput("lc_hold_out",   32'(bus.out),  32'h2F);

        applyStimulus(8'h81, 1'b0, SH_ROR, 4'd1, lat, sb, om);
        checkOutput("ror_lat",    32'(lat),      32'd2);
        checkOutput("ror_out",    32'(bus.out),  32'hC0);
        checkOutput("ror_cout",   32'(bus.cout), 32'h1);
        checkOutput("ror_stable", 32'(om),       32'h0);

        // Started immediately after the previous done: back-to-back accept.
        applyStimulus(8'h80, 1'b0, SH_RCL, 4'd9, lat, sb, om);
        checkOutput("rcl9_lat",  32'(lat),      32'd10);
        checkOutput("rcl9_out",  32'(bus.out),  32'h80);
        checkOutput("rcl9_cout", 32'(bus.cout), 32'h0);

        applyStimulus(8'h80, 1'b0, SH_RCL, 4'd1, lat, sb, om);
        checkOutput("rcl1_out",  32'(bus.out),  32'h00);
        checkOutput("rcl1_cout", 32'(bus.cout), 32'h1);

        applyStimulus(8'h3C, 1'b1, SH_ROR, 4'd0, lat, sb, om);
        checkOutput("zero_lat",  32'(lat),      32'd1);
        checkOutput("zero_out",  32'(bus.out),  32'h3C);
        checkOutput("zero_cout", 32'(bus.cout), 32'h1);
        checkOutput("zero_busy", 32'(sb),       32'h0);

`ifdef SHIFT_ARITH_EN
        exp_rz = 8'hE4;
`else
        exp_rz = 8'h24;
`endif
        applyStimulus(8'h90, 1'b0, SH_RZ, 4'd2, lat, sb, om);
        checkOutput("rz_out",  32'(bus.out),  32'(exp_rz));
        checkOutput("rz_cout", 32'(bus.cout), 32'h0);

        applyStimulus(8'h0F, 1'b1, SH_RC, 4'd2, lat, sb, om);
        checkOutput("rc_out",  32'(bus.out),  32'hC3);
        checkOutput("rc_cout", 32'(bus.cout), 32'h1);

        applyStimulus(8'hFF, 1'b1, SH_LZ, 4'd10, lat, sb, om);
        checkOutput("lz10_lat",  32'(lat),      32'd11);
        checkOutput("lz10_out",  32'(bus.out),  32'h00);
        checkOutput("lz10_cout", 32'(bus.cout), 32'h0);

        applyStimulus(8'hB4, 1'b1, SH_ROL, 4'd8, lat, sb, om);
        checkOutput("rol8_out",  32'(bus.out),  32'hB4);
        checkOutput("rol8_cout", 32'(bus.cout), 32'h0);

        applyStimulus(8'h01, 1'b0, SH_RCR, 4'd1, lat, sb, om);
        checkOutput("rcr1_out",  32'(bus.out),  32'h00);
        checkOutput("rcr1_cout", 32'(bus.cout), 32'h1);

        // start pulsed mid-operation must be ignored.
        @(negedge clk);
        bus.in_data = 8'hA5;
        bus.cin     = 1'b1;
        bus.mode    = SH_LC;
        bus.amount  = 4'd5;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("ign_ready_low", 32'(bus.ready), 32'h0);
        @(negedge clk);
        bus.in_data = 8'h00;
        bus.cin     = 1'b0;
        bus.mode    = SH_LZ;
        bus.amount  = 4'd1;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("ign_lat",  32'(lat),      32'd6);
        checkOutput("ign_out",  32'(bus.out),  32'hBF);
        checkOutput("ign_cout", 32'(bus.cout), 32'h0);

        // Reset during an operation aborts it without a done pulse.
        @(negedge clk);
        bus.in_data = 8'h5A;
        bus.cin     = 1'b1;
        bus.mode    = SH_ROL;
        bus.amount  = 4'd5;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_out",   32'(bus.out),   32'h00);
        checkOutput("abort_cout",  32'(bus.cout),  32'h0);
        checkOutput("abort_ready", 32'(bus.ready), 32'h1);
        checkOutput("abort_busy",  32'(bus.busy),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
